// File: rtl/cmd_write_dispatcher_pkg.sv
// ============================================================================
// Module : cmd_write_dispatcher_pkg
// Brief  : Shared frame constants, state encoding and helpers for the
//          write-channel dispatcher. Optional macro: CMD_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cmd_write_dispatcher_pkg;

    localparam int FRAME_SYNC_BIT = 7;

`ifdef CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GOT_A  = 3'd1;
    localparam logic [2:0] ST_GOT_D2 = 3'd2;
    localparam logic [2:0] ST_GOT_D1 = 3'd3;
    localparam logic [2:0] ST_STROBE = 3'd4;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] ST_CHK    = 3'd5;
`endif

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        GOT_A  = ST_GOT_A,
        GOT_D2 = ST_GOT_D2,
        GOT_D1 = ST_GOT_D1,
        STROBE = ST_STROBE
`ifdef CMD_CHECKSUM_EN
        ,CHK   = ST_CHK
`endif
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_write_dispatcher_tick_divider.sv
// ============================================================================
// Module : tick_divider
// Brief  : Free-running counter emitting a one-cycle tick every TICK_DIV clks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/cmd_write_dispatcher.sv
// ============================================================================
// Module : cmd_write_dispatcher
// Brief  : Assembles ADDR,D2,D1,D0[,CHK] byte frames into 24-bit writes and
//          strobes the addressed peripheral. Optional macro: CMD_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cmd_write_dispatcher
    import cmd_write_dispatcher_pkg::*;
#(
    parameter int NUM_DEV       = 8,
    parameter int TICK_DIV      = 50000,
    parameter int TIMEOUT_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [23:0]        out_data,
    output logic [NUM_DEV-1:0] out_wr,
    output logic               frame_err,
    output logic [7:0]         err_cnt,
    output logic               busy
);

    localparam logic [7:0] c_to_last = 8'(TIMEOUT_TICKS - 1);

`ifdef CMD_CHECKSUM_EN
    localparam int SHADOW_W = 24;
`else
    localparam int SHADOW_W = 16;
`endif

    state_t              r_state, w_state_nxt;
    logic [6:0]          r_idx;
    logic [SHADOW_W-1:0] r_shadow;
    logic [23:0]         r_out_data;
    logic                r_frame_err;
    logic [7:0]          r_err_cnt;
    logic [7:0]          r_to_cnt;
    logic                w_tick;
    logic                w_accept;
    logic                w_busy;
    logic                w_data_byte;
    logic                w_idx_ok;
    logic                w_to_expire;
    logic                w_abort;
    logic                w_load_out;
    logic [23:0]         w_frame_data;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]          r_xor;
`endif

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_accept    = rx_valid && rx_ready;
    assign w_data_byte = w_accept && (r_state inside {GOT_A, GOT_D2, GOT_D1});
    assign w_idx_ok    = (32'(r_idx) < NUM_DEV);
    // A byte arriving in the expiry cycle keeps the frame alive.
    assign w_to_expire = w_busy && w_tick && !w_accept && (r_to_cnt == c_to_last);

`ifdef CMD_CHECKSUM_EN
    assign w_busy       = r_state inside {GOT_A, GOT_D2, GOT_D1, CHK};
    assign w_frame_data = r_shadow;
`else
    assign w_busy       = r_state inside {GOT_A, GOT_D2, GOT_D1};
    assign w_frame_data = {r_shadow, rx_data};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && rx_data[FRAME_SYNC_BIT]) w_state_nxt = GOT_A;
            end
            GOT_A, GOT_D2: begin
                if (w_accept) begin
                    w_state_nxt = (r_state == GOT_A) ? GOT_D2 : GOT_D1;
                end else if (w_to_expire) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end
            end
            GOT_D1: begin
                if (w_accept) begin
`ifdef CMD_CHECKSUM_EN
                    w_state_nxt = CHK;
`else
                    if (w_idx_ok) begin
                        w_state_nxt = STROBE;
                        w_load_out  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_abort     = 1'b1;
                    end
`endif
                end else if (w_to_expire) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end
            end
`ifdef CMD_CHECKSUM_EN
            CHK: begin
                if (w_accept) begin
                    if (w_idx_ok && (rx_data == r_xor)) begin
                        w_state_nxt = STROBE;
                        w_load_out  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_abort     = 1'b1;
                    end
                end else if (w_to_expire) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end
            end
`endif
            STROBE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
            r_to_cnt    <= '0;
`ifdef CMD_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_abort;
            if (w_abort) r_err_cnt <= sat_inc(r_err_cnt);
            if (w_load_out) r_out_data <= w_frame_data;
            if (r_state == IDLE && w_accept && rx_data[FRAME_SYNC_BIT]) begin
                r_idx <= rx_data[6:0];
`ifdef CMD_CHECKSUM_EN
                r_xor <= rx_data;
`endif
            end
            if (w_data_byte) begin
                r_shadow <= {r_shadow[SHADOW_W-9:0], rx_data};
`ifdef CMD_CHECKSUM_EN
                r_xor    <= r_xor ^ rx_data;
`endif
            end
            if (w_accept || !w_busy) r_to_cnt <= '0;
            else if (w_tick)         r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_wr
        assign out_wr[gi] = (r_state == STROBE) && (r_idx == 7'(gi));
    end

    assign rx_ready  = (r_state != STROBE);
    assign busy      = w_busy;
    assign out_data  = r_out_data;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cmd_write_dispatcher.sv
// ============================================================================
// Module : tb_cmd_write_dispatcher
// Brief  : Directed self-checking bench for cmd_write_dispatcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cmd_write_dispatcher;

    localparam int NUM_DEV       = 8;
    localparam int TICK_DIV      = 10;
    localparam int TIMEOUT_TICKS = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic               rx_ready;
    logic [23:0]        out_data;
    logic [NUM_DEV-1:0] out_wr;
    logic               frame_err;
    logic [7:0]         err_cnt;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_write_dispatcher #(
        .NUM_DEV       (NUM_DEV),
        .TICK_DIV      (TICK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .out_data  (out_data),
        .out_wr    (out_wr),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!rx_ready) begin
            n_fail++;
            $display("FAIL send_byte_ready: rx_ready=%0b required 1", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
        send_byte(a);
        send_byte(d2);
        send_byte(d1);
        send_byte(d0);
`ifdef CMD_CHECKSUM_EN
        send_byte(a ^ d2 ^ d1 ^ d0);
`endif
    endtask

    task automatic test_reset();
        #1;
        n_checks += 6;
        if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
        if (out_wr !== 8'h00) begin n_fail++; $display("FAIL reset_out_wr: got %b want 0", out_wr); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_write();
        send_byte(8'h81);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h2C);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h81 ^ 8'h00 ^ 8'h01 ^ 8'h2C);
`endif
        n_checks += 5;
        if (out_wr !== 8'b0000_0010) begin n_fail++; $display("FAIL basic_out_wr: got %b want 00000010", out_wr); end
        if (out_data !== 24'h00012C) begin n_fail++; $display("FAIL basic_out_data: got %h want 00012c", out_data); end
        if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_strobe_ready: got %b want 0", rx_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_strobe_busy: got %b want 0", busy); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
        @(posedge clk); #1;
        n_checks += 3;
        if (out_wr !== 8'h00) begin n_fail++; $display("FAIL basic_strobe_len: got %b want 0", out_wr); end
        if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %b want 1", rx_ready); end
        if (out_data !== 24'h00012C) begin n_fail++; $display("FAIL basic_data_hold: got %h want 00012c", out_data); end
    endtask

    task automatic test_resync();
        send_byte(8'h05);
        @(posedge clk); #1;
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL resync_busy: got %b want 0", busy); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL resync_frame_err: got %b want 0", frame_err); end
        send_frame(8'h83, 8'hAA, 8'hBB, 8'hCC);
        n_checks += 3;
        if (out_wr !== 8'b0000_1000) begin n_fail++; $display("FAIL resync_out_wr: got %b want 00001000", out_wr); end
        if (out_data !== 24'hAABBCC) begin n_fail++; $display("FAIL resync_out_data: got %h want aabbcc", out_data); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL resync_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_bad_index();
        send_frame(8'h8A, 8'h11, 8'h22, 8'h33);
        n_checks += 5;
        if (out_wr !== 8'h00) begin n_fail++; $display("FAIL badidx_out_wr: got %b want 0", out_wr); end
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL badidx_frame_err: got %b want 1", frame_err); end
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL badidx_err_cnt: got %0d want 1", err_cnt); end
        if (out_data !== 24'hAABBCC) begin n_fail++; $display("FAIL badidx_out_data: got %h want aabbcc", out_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL badidx_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL badidx_err_pulse: got %b want 0", frame_err); end
    endtask

    task automatic test_timeout();
        int  cyc;
        logic seen;
        send_byte(8'h80);
        send_byte(8'h12);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < (TIMEOUT_TICKS + 1) * TICK_DIV + 5) begin
            @(posedge clk); #1;
            cyc++;
            if (frame_err) seen = 1'b1;
        end
        n_checks += 5;
        if (!seen) begin n_fail++; $display("FAIL timeout_seen: frame_err never pulsed within %0d cycles", cyc); end
        if (cyc < (TIMEOUT_TICKS - 1) * TICK_DIV) begin n_fail++; $display("FAIL timeout_early: fired after %0d cycles want >= %0d", cyc, (TIMEOUT_TICKS - 1) * TICK_DIV); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
        if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d want 2", err_cnt); end
        if (out_data !== 24'hAABBCC) begin n_fail++; $display("FAIL timeout_out_data: got %h want aabbcc", out_data); end
        send_frame(8'h80, 8'h00, 8'h00, 8'h07);
        n_checks += 2;
        if (out_wr !== 8'b0000_0001) begin n_fail++; $display("FAIL timeout_next_wr: got %b want 00000001", out_wr); end
        if (out_data !== 24'h000007) begin n_fail++; $display("FAIL timeout_next_data: got %h want 000007", out_data); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 253; i++) send_frame(8'hFF, 8'h01, 8'h02, 8'h03);
        n_checks++;
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d want 255", err_cnt); end
        send_frame(8'h90, 8'h01, 8'h02, 8'h03);
        n_checks += 2;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL sat_frame_err: got %b want 1", frame_err); end
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
    endtask

    task automatic test_mid_reset();
        send_byte(8'h82);
        send_byte(8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b want 0", busy); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mrst_err_cnt: got %0d want 0", err_cnt); end
        if (out_data !== 24'h0) begin n_fail++; $display("FAIL mrst_out_data: got %h want 000000", out_data); end
        if (out_wr !== 8'h00) begin n_fail++; $display("FAIL mrst_out_wr: got %b want 0", out_wr); end
        if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_rx_ready: got %b want 1", rx_ready); end
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h82, 8'hDE, 8'hAD, 8'h01);
        n_checks += 3;
        if (out_wr !== 8'b0000_0100) begin n_fail++; $display("FAIL mrst_out_wr2: got %b want 00000100", out_wr); end
        if (out_data !== 24'hDEAD01) begin n_fail++; $display("FAIL mrst_out_data2: got %h want dead01", out_data); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mrst_err_cnt2: got %0d want 0", err_cnt); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h85, 8'h12, 8'h34, 8'h56);
        n_checks += 2;
        if (out_wr !== 8'b0010_0000) begin n_fail++; $display("FAIL b2b_wr1: got %b want 00100000", out_wr); end
        if (out_data !== 24'h123456) begin n_fail++; $display("FAIL b2b_data1: got %h want 123456", out_data); end
        send_frame(8'h86, 8'h65, 8'h43, 8'h21);
        n_checks += 2;
        if (out_wr !== 8'b0100_0000) begin n_fail++; $display("FAIL b2b_wr2: got %b want 01000000", out_wr); end
        if (out_data !== 24'h654321) begin n_fail++; $display("FAIL b2b_data2: got %h want 654321", out_data); end
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_checksum();
        send_byte(8'h81); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h81);
        n_checks += 2;
        if (out_wr !== 8'b0000_0010) begin n_fail++; $display("FAIL chk_ok_wr: got %b want 00000010", out_wr); end
        if (out_data !== 24'h010203) begin n_fail++; $display("FAIL chk_ok_data: got %h want 010203", out_data); end
        @(posedge clk); #1;
        send_byte(8'h81); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h00);
        n_checks += 3;
        if (out_wr !== 8'h00) begin n_fail++; $display("FAIL chk_bad_wr: got %b want 0", out_wr); end
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL chk_bad_err: got %b want 1", frame_err); end
        if (out_data !== 24'h010203) begin n_fail++; $display("FAIL chk_bad_data: got %h want 010203", out_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_write();
        test_resync();
        test_bad_index();
        test_timeout();
        test_saturation();
        test_mid_reset();
        test_back_to_back();
`ifdef CMD_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
